// File: rtl/sar_adc_pkg.sv
// ----------------------------------------------------------------------------
// sar_adc_pkg
//   Shared definitions for the SAR conversion controller: FSM state encoding,
//   control-register bit positions (common with the SPI slave register map)
//   and the smallest legal values of the controller parameters.
// ----------------------------------------------------------------------------
package sar_adc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SAMPLE  = 2'd1,
    ST_CONVERT = 2'd2,
    ST_DONE    = 2'd3
  } sar_state_t;

  // Control register bit positions.
  localparam int CTRL_EN    = 0;
  localparam int CTRL_START = 1;
  localparam int CTRL_CONT  = 2;

  // Smallest legal parameter values. SETTLE needs 3 clocks: one for the DAC
  // and two for the comparator synchronizer.
  localparam int MIN_WIDTH         = 4;
  localparam int MIN_SAMPLE_CYCLES = 1;
  localparam int MIN_SETTLE_CYCLES = 3;

endpackage

// File: rtl/sar_comp_sync.sv
// ----------------------------------------------------------------------------
// sar_comp_sync
//   Two-flop synchronizer bringing the asynchronous comparator output into
//   the clk domain.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset, clears both flops
//   async_in in  asynchronous comparator output
//   sync_out out synchronized comparator value (two clocks of latency)
// ----------------------------------------------------------------------------
module sar_comp_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample
  // their inputs from before the edge; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta     <= 1'b0;
      sync_out <= 1'b0;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/sar_adc_ctrl.sv
// ----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation conversion controller. Sequences track, bit-by-
//   bit conversion against an external comparator/DAC and result delivery to
//   the SPI slave. All outputs are registered.
// Ports:
//   clk            in  system clock (shared with the SPI slave)
//   reset          in  synchronous active-high reset
//   ctrl_reg_in    in  SPI control register: [0] EN, [1] START, [2] CONT
//   comp_in        in  asynchronous comparator, 1 = Vin >= Vdac
//   sample_en      out track/hold switch, 1 = track
//   dac_code       out trial code for the capacitive DAC
//   adc_data       out last completed result
//   adc_busy       out conversion in progress
//   adc_eoc_pulse  out one-cycle end-of-conversion pulse
//   hw_clear_start out one-cycle strobe clearing START in the SPI slave
// Parameters: WIDTH >= 4, SAMPLE_CYCLES >= 1, SETTLE_CYCLES >= 3.
// ----------------------------------------------------------------------------
module sar_adc_ctrl
  import sar_adc_pkg::*;
#(
  parameter int WIDTH         = 12,
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] ctrl_reg_in,
  input  logic             comp_in,
  output logic             sample_en,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] adc_data,
  output logic             adc_busy,
  output logic             adc_eoc_pulse,
  output logic             hw_clear_start
);

  localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_CYCLES) ? SAMPLE_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(WIDTH);

  sar_state_t       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] bit_idx, bit_idx_nxt;
  logic [WIDTH-1:0] trial, trial_nxt;
  logic [WIDTH-1:0] dac_code_nxt, adc_data_nxt;
  logic             hcs_nxt;
  logic             comp_sync;

  logic en, start, cont;
  assign en    = ctrl_reg_in[CTRL_EN];
  assign start = ctrl_reg_in[CTRL_START];
  assign cont  = ctrl_reg_in[CTRL_CONT];

  // Remaining control bits are reserved.
  logic unused_ctrl;
  assign unused_ctrl = ^ctrl_reg_in[WIDTH-1:CTRL_CONT+1];

  sar_comp_sync u_sync (
    .clk      (clk),
    .reset    (reset),
    .async_in (comp_in),
    .sync_out (comp_sync)
  );

  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    bit_idx_nxt  = bit_idx;
    trial_nxt    = trial;
    adc_data_nxt = adc_data;
    hcs_nxt      = 1'b0;

    unique case (state)
      ST_IDLE: begin
        cnt_nxt = '0;
        if (en && start) begin
          state_nxt = ST_SAMPLE;
          hcs_nxt   = 1'b1;
        end
      end

      ST_SAMPLE: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(SAMPLE_CYCLES - 1)) begin
          state_nxt   = ST_CONVERT;
          cnt_nxt     = '0;
          bit_idx_nxt = IDX_W'(WIDTH - 1);
          trial_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CONVERT: begin
        if (!en) begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_W'(SETTLE_CYCLES - 1)) begin
          // Last settle clock: the synchronized comparator now reflects the
          // current trial code. Only kept bits live in the trial register.
          cnt_nxt = '0;
          if (comp_sync) trial_nxt = trial | (WIDTH'(1) << bit_idx);
          if (bit_idx == '0) begin
            state_nxt    = ST_DONE;
            adc_data_nxt = trial_nxt;
          end else begin
            bit_idx_nxt = bit_idx - IDX_W'(1);
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_DONE: begin
        cnt_nxt = '0;
        if (en && cont) begin
          state_nxt = ST_SAMPLE;
        end else if (en && start) begin
          state_nxt = ST_SAMPLE;
          hcs_nxt   = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase

    // Outputs are computed from the next state so they can be registered
    // without adding a cycle of latency.
    dac_code_nxt = (state_nxt == ST_CONVERT) ? (trial_nxt | (WIDTH'(1) << bit_idx_nxt)) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      bit_idx        <= '0;
      trial          <= '0;
      sample_en      <= 1'b1;
      dac_code       <= '0;
      adc_data       <= '0;
      adc_busy       <= 1'b0;
      adc_eoc_pulse  <= 1'b0;
      hw_clear_start <= 1'b0;
    end else begin
      state          <= state_nxt;
      cnt            <= cnt_nxt;
      bit_idx        <= bit_idx_nxt;
      trial          <= trial_nxt;
      sample_en      <= (state_nxt == ST_IDLE) || (state_nxt == ST_SAMPLE);
      dac_code       <= dac_code_nxt;
      adc_data       <= adc_data_nxt;
      adc_busy       <= (state_nxt == ST_SAMPLE) || (state_nxt == ST_CONVERT);
      adc_eoc_pulse  <= (state_nxt == ST_DONE);
      hw_clear_start <= hcs_nxt;
    end
  end

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sar_adc_ctrl
//   Self-checking bench for sar_adc_ctrl with default parameters. An ideal
//   comparator (dac_code <= model_val) stands in for the analog front end;
//   the bench also plays the SPI slave by clearing START on hw_clear_start.
// ----------------------------------------------------------------------------
module tb_sar_adc_ctrl;
  import sar_adc_pkg::*;

  localparam int W = 12;
  localparam int S = 4;
  localparam int T = 3;
  localparam int P = S + W * T + 1;   // conversion length in clocks

  logic          clk = 1'b0;
  logic          reset;
  logic [W-1:0]  ctrl_reg_in;
  logic          comp_in;
  logic          sample_en;
  logic [W-1:0]  dac_code;
  logic [W-1:0]  adc_data;
  logic          adc_busy;
  logic          adc_eoc_pulse;
  logic          hw_clear_start;

  int            model_val;
  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  int            exp_data = 0;
  int            eoc_q[$];
  int            hcs_q[$];

  always #5 clk = ~clk;

  // Ideal comparator: Vin >= Vdac.
  assign comp_in = (int'(dac_code) <= model_val);

  sar_adc_ctrl #(.WIDTH(W), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(T)) dut (
    .clk            (clk),
    .reset          (reset),
    .ctrl_reg_in    (ctrl_reg_in),
    .comp_in        (comp_in),
    .sample_en      (sample_en),
    .dac_code       (dac_code),
    .adc_data       (adc_data),
    .adc_busy       (adc_busy),
    .adc_eoc_pulse  (adc_eoc_pulse),
    .hw_clear_start (hw_clear_start)
  );

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock; sample after the edge and mimic the SPI slave clearing START.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (adc_eoc_pulse) eoc_q.push_back(cyc);
    if (hw_clear_start) begin
      hcs_q.push_back(cyc);
      ctrl_reg_in[CTRL_START] = 1'b0;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sample_en"}, int'(sample_en), 1);
    check({tag, "_dac"},       int'(dac_code), 0);
    check({tag, "_data"},      int'(adc_data), 0);
    check({tag, "_busy"},      int'(adc_busy), 0);
    check({tag, "_eoc"},       int'(adc_eoc_pulse), 0);
    check({tag, "_hcs"},       int'(hw_clear_start), 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_sample_en"}, int'(sample_en), 1);
    check({tag, "_dac"},       int'(dac_code), 0);
    check({tag, "_busy"},      int'(adc_busy), 0);
    check({tag, "_eoc"},       int'(adc_eoc_pulse), 0);
    check({tag, "_data"},      int'(adc_data), exp_data);
  endtask

  // Expected outputs at position p (1..P) of a conversion of value v.
  task automatic check_phase(input int p, input int v, input bit hcs_first);
    int k, i, trial_code;
    if (p <= S) begin
      check("smp_sample_en", int'(sample_en), 1);
      check("smp_busy",      int'(adc_busy), 1);
      check("smp_eoc",       int'(adc_eoc_pulse), 0);
      check("smp_hcs",       int'(hw_clear_start), int'(p == 1 && hcs_first));
      check("smp_data",      int'(adc_data), exp_data);
    end else if (p < P) begin
      k = (p - S - 1) / T;
      i = W - 1 - k;
      // Bits above i already resolved to those of v, bit i under trial.
      trial_code = ((v >> (i + 1)) << (i + 1)) | (1 << i);
      check("cnv_dac",       int'(dac_code), trial_code);
      check("cnv_sample_en", int'(sample_en), 0);
      check("cnv_busy",      int'(adc_busy), 1);
      check("cnv_eoc",       int'(adc_eoc_pulse), 0);
      check("cnv_hcs",       int'(hw_clear_start), 0);
    end else begin
      check("done_eoc",  int'(adc_eoc_pulse), 1);
      check("done_busy", int'(adc_busy), 0);
      check("done_data", int'(adc_data), v);
      exp_data = v;
    end
  endtask

  task automatic run(input int p0, input int p1, input int v, input bit hcs_first);
    model_val = v;
    for (int p = p0; p <= p1; p++) begin
      tick();
      check_phase(p, v, hcs_first);
    end
  endtask

  task automatic start(input bit cont);
    cyc = 0;
    eoc_q.delete();
    hcs_q.delete();
    ctrl_reg_in = '0;
    ctrl_reg_in[CTRL_EN]    = 1'b1;
    ctrl_reg_in[CTRL_START] = 1'b1;
    ctrl_reg_in[CTRL_CONT]  = cont;
  endtask

  task automatic go_idle();
    ctrl_reg_in = '0;
    tick();
    tick();
  endtask

  initial begin
    int v1, v2, v3;
    reset       = 1'b1;
    ctrl_reg_in = '0;
    model_val   = 0;
    tick();
    tick();
    check_reset_vals("rst");
    reset = 1'b0;
    tick();
    check_idle("post_rst");

    // 1: single conversion, mid-scale.
    start(1'b0);
    run(1, P, 'hA5C, 1'b1);
    check("t1_eoc_cnt",  eoc_q.size(), 1);
    check("t1_eoc_cyc",  (eoc_q.size() > 0) ? eoc_q[0] : -1, 41);
    check("t1_hcs_cnt",  hcs_q.size(), 1);
    check("t1_hcs_cyc",  (hcs_q.size() > 0) ? hcs_q[0] : -1, 1);
    tick();
    check_idle("t1_idle");
    go_idle();

    // 2: boundary values.
    start(1'b0);
    run(1, P, 'h000, 1'b1);
    go_idle();
    start(1'b0);
    run(1, P, 'hFFF, 1'b1);
    go_idle();

    // 3: continuous mode with a new value each conversion.
    v1 = int'($urandom_range(0, 4095));
    v2 = int'($urandom_range(0, 4095));
    v3 = int'($urandom_range(0, 4095));
    start(1'b1);
    run(1, P, v1, 1'b1);
    run(1, P, v2, 1'b0);
    run(1, P, v3, 1'b0);
    ctrl_reg_in = '0;
    tick();
    check_idle("t3_idle");
    check("t3_eoc_cnt", eoc_q.size(), 3);
    check("t3_eoc0",    (eoc_q.size() > 0) ? eoc_q[0] : -1, 41);
    check("t3_eoc1",    (eoc_q.size() > 1) ? eoc_q[1] : -1, 82);
    check("t3_eoc2",    (eoc_q.size() > 2) ? eoc_q[2] : -1, 123);
    check("t3_hcs_cnt", hcs_q.size(), 1);
    go_idle();

    // 4: abort by dropping EN at cycle 20.
    start(1'b0);
    run(1, 20, int'($urandom_range(0, 4095)), 1'b1);
    ctrl_reg_in = '0;
    tick();
    check_idle("t4_abort");
    for (int n = 0; n < 30; n++) tick();
    check_idle("t4_later");
    check("t4_no_eoc", eoc_q.size(), 0);

    // 5: reset pulse at cycle 15, then a normal conversion.
    start(1'b0);
    run(1, 15, int'($urandom_range(0, 4095)), 1'b1);
    reset = 1'b1;
    tick();
    check_reset_vals("t5_rst");
    check("t5_no_eoc", eoc_q.size(), 0);
    exp_data    = 0;
    reset       = 1'b0;
    ctrl_reg_in = '0;
    tick();
    check_idle("t5_idle");
    start(1'b0);
    run(1, P, int'($urandom_range(0, 4095)), 1'b1);
    go_idle();

    // 6: START rewritten while busy is consumed at DONE.
    v1 = int'($urandom_range(0, 4095));
    v2 = int'($urandom_range(0, 4095));
    start(1'b0);
    run(1, 10, v1, 1'b1);
    ctrl_reg_in[CTRL_START] = 1'b1;
    run(11, P, v1, 1'b1);
    run(1, P, v2, 1'b1);
    tick();
    check_idle("t6_idle");
    check("t6_eoc_cnt", eoc_q.size(), 2);
    check("t6_eoc0",    (eoc_q.size() > 0) ? eoc_q[0] : -1, 41);
    check("t6_eoc1",    (eoc_q.size() > 1) ? eoc_q[1] : -1, 82);
    check("t6_hcs_cnt", hcs_q.size(), 2);
    check("t6_hcs1",    (hcs_q.size() > 1) ? hcs_q[1] : -1, 42);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation conversion controller sitting directly upstream of `adc_spi_slave`. It takes the SPI control register, runs sample/convert sequencing against an external analog comparator and capacitive DAC, and delivers the result, busy flag, end-of-conversion pulse and start-clear strobe back to the SPI slave's ADC-side inputs. All logic runs in one clock domain; only `comp_in` is asynchronous.

## Interface
- `WIDTH`, 12: result, DAC code and control word width; must be ≥ 4.
- `SAMPLE_CYCLES`, 4: number of clocks the track switch stays closed; must be ≥ 1.
- `SETTLE_CYCLES`, 3: number of clocks per bit decision, covering DAC settling and the 2-flop synchronizer; must be ≥ 3.

Ports:
- `clk`  in  1  system clock, the same clock as the SPI slave.
- `reset`  in  1  synchronous, active-high reset.
- `ctrl_reg_in`  in  WIDTH  the SPI control register. Bit 0 is EN, bit 1 is START, bit 2 is CONT; all other bits are ignored.
- `comp_in`  in  1  asynchronous comparator output; 1 means Vin ≥ Vdac.
- `sample_en`  out  1  track/hold switch; 1 means track.
- `dac_code`  out  WIDTH  trial code driven to the DAC.
- `adc_data`  out  WIDTH  last completed result.
- `adc_busy`  out  1  a conversion is in progress.
- `adc_eoc_pulse`  out  1  one-cycle pulse marking a completed result.
- `hw_clear_start`  out  1  one-cycle strobe that clears START in the SPI slave.

## Operation
FSM states are IDLE, SAMPLE, CONVERT and DONE.

- **IDLE**
  - `sample_en`=1 and `dac_code`=0.
  - If EN=1 and START=1, go to SAMPLE and register `hw_clear_start`=1 for exactly the first SAMPLE cycle.
  - START is level-sensitive, but IDLE is left immediately, so a single write never triggers twice.
- **SAMPLE**
  - `sample_en`=1 and `adc_busy`=1.
  - Stay for SAMPLE_CYCLES clocks, then go to CONVERT with bit index i=WIDTH-1 and trial register cleared to 0.
- **CONVERT**
  - `sample_en`=0 and `adc_busy`=1.
  - `dac_code` = trial | (1<<i), held for SETTLE_CYCLES clocks.
  - On the last clock, sample the synchronized comparator value. If it is 1, keep bit i; otherwise clear bit i.
  - If i=0, go to DONE; otherwise decrement i.
- **DONE** (exactly 1 clock)
  - `adc_data` takes the final trial value.
  - `adc_eoc_pulse`=1 and `adc_busy`=0.
  - Next state:
    - CONT=1 and EN=1: go to SAMPLE, with no `hw_clear_start`.
    - Otherwise, START=1 and EN=1: go to SAMPLE and pulse `hw_clear_start`.
    - Otherwise: go to IDLE.
- **EN drops to 0 in SAMPLE or CONVERT**
  - Abort to IDLE on the next clock.
  - No eoc pulse, and `adc_data` is unchanged.
  - `dac_code` returns to 0 and `adc_busy` returns to 0.
- **Comparator synchronization:** `comp_in` passes through 2 flops before use. The decision always uses the value sampled on the last settle clock of the bit.

## Timing
- **Reset values:**
  - State IDLE.
  - `sample_en`=1.
  - `dac_code`=0 and `adc_data`=0.
  - `adc_busy`=0, `adc_eoc_pulse`=0 and `hw_clear_start`=0.
  - Synchronizer flops and counters cleared.
- **Reset mid-conversion:** returns to the reset values on the next clock. No eoc pulse is emitted.
- **Latency:** with cycle 0 being the clock edge where IDLE sees EN&START, `adc_eoc_pulse` is high in cycle 1+SAMPLE_CYCLES+WIDTH·SETTLE_CYCLES. For the default parameters that is cycle 41.
- **Output registration:** all outputs are registered. `adc_data` is valid in the same cycle as `adc_eoc_pulse` and holds until the next DONE.
- **Continuous mode period:** SAMPLE_CYCLES+WIDTH·SETTLE_CYCLES+1 clocks, which is 41 by default.
- **Overlapping START:** a START written while busy is acted on only at DONE, and that is the only time it can be consumed. START is never lost.
- **Simultaneous events:**
  - EN=0 in the DONE cycle still completes DONE: eoc is issued and the FSM then goes to IDLE.
  - Reset wins over everything.

## Structure
- **Shared package `sar_adc_pkg`:**
  - State encoding.
  - Control bit indices CTRL_EN=0, CTRL_START=1 and CTRL_CONT=2, which are shared with the SPI slave's register map.
  - Minimum-parameter constants.
- **Sub-module `sar_comp_sync`:** 2-flop synchronizer with synchronous active-high reset.

## Test plan
1. **Single conversion, mid-scale value.** Use WIDTH=12, SAMPLE=4, SETTLE=3. The comparator model drives comp=(dac_code ≤ 0xA5C). Set EN=1, START=1. Required response:
   - `hw_clear_start` is high for cycle 1 only.
   - `adc_eoc_pulse` is high at cycle 41 only.
   - `adc_data`=0xA5C and `adc_busy` is high for cycles 1–40.
2. **Boundary input values.** A model value of 0x000 yields 0x000. A model value of 0xFFF yields 0xFFF. Each trial in between is checked: the first trial is 0x800 and the second is 0xC00 for the 0xFFF case.
3. **Continuous mode.** Set CONT=1, EN=1 and START once. Required response:
   - eoc pulses at cycles 41, 82 and 123.
   - Exactly one `hw_clear_start`.
   - Changing the model value between conversions updates `adc_data`.
4. **Abort.** Drop EN at cycle 20. Required response:
   - The FSM is in IDLE next cycle with `adc_busy`=0 and `dac_code`=0.
   - No eoc pulse.
   - `adc_data` keeps its prior value.
5. **Reset mid-conversion.** Assert `reset` for 1 cycle at cycle 15. Required response:
   - All outputs are at their reset values on the next cycle.
   - No eoc pulse.
   - A new START afterwards converts normally.
6. **START while busy.** Set START=1 again at cycle 10 with CONT=0. Required response:
   - First eoc at cycle 41.
   - `hw_clear_start` pulses at cycle 42.
   - Second eoc at cycle 82.
